mc_exec_core: RTL and testbench

- Multicycle execute core for the 32-bit MIPS processor.
- Fetches one instruction per pass through an imem request/valid handshake, decodes R-type add/sub/and/or/nor/slt and I-type addi, reads an internal register file, executes and writes back.
- Emits a one-cycle retire trace, so the benches check results without hierarchical probing.
- Generalises the fixed 32-bit single-cycle datapath in data width, register count and PC width, and adds an immediate mode, an illegal-op flag and a retire counter.

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/mc_exec_core_if.sv | 24 ++
 rtl/mc_alu.sv | 27 ++
 rtl/mc_exec_core.sv | 175 +++++++++++++++++
 tb/tb_mc_exec_core.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle execute core:
// opcode/funct encodings, instruction field positions, ALU op and FSM state enums.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_LO  = 21;
    localparam int RT_LO  = 16;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

endpackage

// File: rtl/mc_exec_core_if.sv
// Instruction memory request/valid handshake.
// master (core): drives imem_req, imem_addr; slave (memory): drives imem_valid, imem_data.
interface mc_exec_core_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/mc_alu.sv
// Combinational ALU for the execute core.
// Ports: a_i, b_i operands; op_i operation; result_o wrapped XLEN-bit result.
module mc_alu
    import mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = XLEN'($signed(a_i) < $signed(b_i));
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_exec_core.sv
// Multicycle execute core: FETCH -> DECODE -> EXEC -> WB, one instruction per pass.
// Ports: clk, reset (async high), run, imem (master handshake), retire_* trace, pc.
module mc_exec_core
    import mc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    mc_exec_core_if.master   imem,
    output logic             retire_valid,
    output logic             retire_illegal,
    output logic [4:0]       retire_rd,
    output logic [XLEN-1:0]  retire_a,
    output logic [XLEN-1:0]  retire_b,
    output logic [XLEN-1:0]  retire_result,
    output logic [31:0]      retire_count,
    output logic [PC_W-1:0]  pc
);

    localparam int IW = $clog2(NREGS);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    alu_op_e         op_q;
    logic            legal_q;
    logic [IW-1:0]   dest_q;

    logic            rv_q;
    logic            ril_q;
    logic [4:0]      rrd_q;
    logic [XLEN-1:0] ra_q;
    logic [XLEN-1:0] rb_q;
    logic [XLEN-1:0] rres_q;
    logic [31:0]     rcnt_q;

    logic [5:0]      opc;
    logic [5:0]      fn;
    logic [IW-1:0]   rs_idx;
    logic [IW-1:0]   rt_idx;
    logic [IW-1:0]   rd_idx;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] b_d;
    alu_op_e         op_d;
    logic            legal_d;
    logic [IW-1:0]   dest_d;
    logic [XLEN-1:0] alu_res;
    logic            unused_shamt;

    assign opc    = ir_q[OPC_HI:OPC_LO];
    assign fn     = ir_q[FN_HI:FN_LO];
    assign rs_idx = ir_q[RS_LO +: IW];
    assign rt_idx = ir_q[RT_LO +: IW];
    assign rd_idx = ir_q[RD_LO +: IW];
    assign rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];
    assign unused_shamt = ^ir_q[SH_HI:SH_LO];

    always_comb begin
        op_d    = ALU_ADD;
        legal_d = 1'b0;
        dest_d  = rd_idx;
        b_d     = rt_val;
        unique case (1'b1)
            opc == OP_ADDI: begin
                legal_d = 1'b1;
                dest_d  = rt_idx;
                b_d     = XLEN'($signed(ir_q[IMM_HI:IMM_LO]));
            end
            opc == OP_RTYPE: begin
                legal_d = 1'b1;
                unique case (fn)
                    FN_ADD:  op_d = ALU_ADD;
                    FN_SUB:  op_d = ALU_SUB;
                    FN_AND:  op_d = ALU_AND;
                    FN_OR:   op_d = ALU_OR;
                    FN_NOR:  op_d = ALU_NOR;
                    FN_SLT:  op_d = ALU_SLT;
                    default: legal_d = 1'b0;
                endcase
            end
            default: legal_d = 1'b0;
        endcase
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_res)
    );

    // Retire trace is loaded on the EXEC->WB edge so the pulse sits in WB;
    // the register file and pc update on the WB->FETCH edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ALU_ADD;
            legal_q <= 1'b0;
            dest_q  <= '0;
            rv_q    <= 1'b0;
            ril_q   <= 1'b0;
            rrd_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rres_q  <= '0;
            rcnt_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rv_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (run && imem.imem_valid) begin
                        ir_q    <= imem.imem_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rs_val;
                    b_q     <= b_d;
                    op_q    <= op_d;
                    legal_q <= legal_d;
                    dest_q  <= dest_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    rv_q    <= 1'b1;
                    ril_q   <= ~legal_q;
                    rrd_q   <= legal_q ? 5'(dest_q) : 5'd0;
                    ra_q    <= a_q;
                    rb_q    <= b_q;
                    rres_q  <= legal_q ? alu_res : '0;
                    rcnt_q  <= rcnt_q + 32'd1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (legal_q && dest_q != '0) begin
                        rf_q[dest_q] <= rres_q;
                    end
                    pc_q    <= pc_q + PC_W'(4);
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Request follows run combinationally so dropping run withdraws it at once.
    assign imem.imem_req  = (state_q == S_FETCH) && run && !reset;
    assign imem.imem_addr = pc_q;

    assign retire_valid   = rv_q;
    assign retire_illegal = ril_q;
    assign retire_rd      = rrd_q;
    assign retire_a       = ra_q;
    assign retire_b       = rb_q;
    assign retire_result  = rres_q;
    assign retire_count   = rcnt_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_mc_exec_core.sv
// Randomized bench for mc_exec_core: 32-bit default instance plus
// an XLEN=16 / NREGS=8 instance, both checked against an ISA-level model.
module tb_mc_exec_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic run32;
    logic run16;

    mc_exec_core_if #(.PC_W(32)) if32 ();
    mc_exec_core_if #(.PC_W(16)) if16 ();

    logic        r32_valid, r32_ill;
    logic [4:0]  r32_rd;
    logic [31:0] r32_a, r32_b, r32_res, r32_cnt, r32_pc;

    logic        r16_valid, r16_ill;
    logic [4:0]  r16_rd;
    logic [15:0] r16_a, r16_b, r16_res, r16_pc;
    logic [31:0] r16_cnt;

    mc_exec_core u_d32 (
        .clk            (clk),
        .reset          (reset),
        .run            (run32),
        .imem           (if32),
        .retire_valid   (r32_valid),
        .retire_illegal (r32_ill),
        .retire_rd      (r32_rd),
        .retire_a       (r32_a),
        .retire_b       (r32_b),
        .retire_result  (r32_res),
        .retire_count   (r32_cnt),
        .pc             (r32_pc)
    );

    mc_exec_core #(.XLEN(16), .NREGS(8), .PC_W(16)) u_d16 (
        .clk            (clk),
        .reset          (reset),
        .run            (run16),
        .imem           (if16),
        .retire_valid   (r16_valid),
        .retire_illegal (r16_ill),
        .retire_rd      (r16_rd),
        .retire_a       (r16_a),
        .retire_b       (r16_b),
        .retire_result  (r16_res),
        .retire_count   (r16_cnt),
        .pc             (r16_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mreg [2][32];
    logic [31:0] mcnt [2];
    logic [31:0] mpc  [2];
    int          xl_of [2] = '{32, 16};
    int          nr_of [2] = '{32, 8};
    logic [5:0]  fns   [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mpc[k]  = 0;
            for (int r = 0; r < 32; r++) mreg[k][r] = 0;
        end
    endtask

    task automatic ref_step(input int k, input logic [31:0] w,
                            output bit ill, output logic [31:0] erd,
                            output logic [31:0] ea, output logic [31:0] eb,
                            output logic [31:0] eres);
        logic [31:0] m;
        int rs, rt, rd, dst, sh, sa, sb;
        m   = (xl_of[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl_of[k]) - 1);
        sh  = 32 - xl_of[k];
        rs  = int'(w[25:21]) % nr_of[k];
        rt  = int'(w[20:16]) % nr_of[k];
        rd  = int'(w[15:11]) % nr_of[k];
        ea  = mreg[k][rs];
        eb  = mreg[k][rt];
        ill = 1'b0;
        eres = 0;
        dst = rd;
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20: eres = ea + eb;
                6'h22: eres = ea - eb;
                6'h24: eres = ea & eb;
                6'h25: eres = ea | eb;
                6'h27: eres = ~(ea | eb);
                6'h2A: begin
                    sa = int'(ea << sh) >>> sh;
                    sb = int'(eb << sh) >>> sh;
                    eres = (sa < sb) ? 32'd1 : 32'd0;
                end
                default: ill = 1'b1;
            endcase
        end else if (w[31:26] == 6'h08) begin
            eb   = {{16{w[15]}}, w[15:0]} & m;
            eres = ea + eb;
            dst  = rt;
        end else begin
            ill = 1'b1;
        end
        eres = eres & m;
        if (ill) begin
            eres = 0;
            dst  = 0;
        end
        erd = 32'(dst);
        if (!ill && dst != 0) mreg[k][dst] = eres;
        mcnt[k] = mcnt[k] + 1;
    endtask

    // ---------------- DUT access helpers ----------------
    function automatic logic req_of(input int k);
        return k != 0 ? if16.imem_req : if32.imem_req;
    endfunction
    function automatic logic rv_of(input int k);
        return k != 0 ? r16_valid : r32_valid;
    endfunction
    function automatic logic [31:0] res_of(input int k);
        return k != 0 ? 32'(r16_res) : r32_res;
    endfunction
    function automatic logic [4:0] rd_of(input int k);
        return k != 0 ? r16_rd : r32_rd;
    endfunction

    task automatic drive(input int k, input logic v, input logic [31:0] w);
        if (k != 0) begin
            if16.imem_valid = v;
            if16.imem_data  = w;
        end else begin
            if32.imem_valid = v;
            if32.imem_data  = w;
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input int rd,
                                          input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction
    function automatic logic [31:0] addi(input int rt, input int rs,
                                         input logic [15:0] imm);
        return {6'h08, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int kind;
        w    = $urandom;
        kind = $urandom_range(0, 9);
        if (kind < 6) w = {6'h00, w[25:6], fns[$urandom_range(0, 5)]};
        else if (kind < 9) w = {6'h08, w[25:0]};
        return w;
    endfunction

    // Called at a negedge; returns at the negedge of the next FETCH cycle.
    task automatic run_instr(input int k, input logic [31:0] w, input int lat);
        int n;
        bit ill;
        logic [31:0] erd, ea, eb, eres, pm;
        logic [2:0] rvs;
        n = 0;
        while (!req_of(k) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_of(k)) begin
            check("req_wait", req_of(k), 1);
            return;
        end
        repeat (lat) @(negedge clk);
        drive(k, 1'b1, w);
        @(posedge clk);
        #1;
        drive(k, 1'b0, $urandom);
        ref_step(k, w, ill, erd, ea, eb, eres);
        rvs = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rvs = {rvs[1:0], rv_of(k)};
        end
        check("retire_timing", rvs, 3'b001);
        check("retire_illegal", k != 0 ? r16_ill : r32_ill, ill);
        check("retire_rd", rd_of(k), erd);
        check("retire_result", res_of(k), eres);
        check("retire_count", k != 0 ? r16_cnt : r32_cnt, mcnt[k]);
        if (!ill) begin
            check("retire_a", k != 0 ? 32'(r16_a) : r32_a, ea);
            check("retire_b", k != 0 ? 32'(r16_b) : r32_b, eb);
        end
        pm = (k != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mpc[k] = (mpc[k] + 32'd4) & pm;
        @(negedge clk);
        check("pc", k != 0 ? 32'(r16_pc) : r32_pc, mpc[k]);
    endtask

    logic saw16 = 1'b0;
    always @(negedge clk) if (if16.imem_req) saw16 <= 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic req_seen;
        reset = 1'b1;
        run32 = 1'b1;
        run16 = 1'b0;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        model_reset();
        #12;
        check("rst_valid", r32_valid, 0);
        check("rst_result", r32_res, 0);
        check("rst_count", r32_cnt, 0);
        check("rst_pc", r32_pc, 0);
        check("rst_req", if32.imem_req, 0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(0, addi(1, 0, 16'd5), 0);
        check("addi_r1", res_of(0), 32'd5);
        check("addi_rd", rd_of(0), 5'd1);
        run_instr(0, addi(2, 0, 16'hFFFD), 0);
        check("addi_neg", res_of(0), 32'hFFFF_FFFD);
        run_instr(0, rtype(6'h20, 3, 1, 2), 0);
        check("add", res_of(0), 32'd2);
        check("count3", r32_cnt, 32'd3);
        check("pc12", r32_pc, 32'd12);

        run_instr(0, rtype(6'h22, 4, 1, 2), 1);
        check("sub", res_of(0), 32'd8);
        run_instr(0, rtype(6'h24, 4, 1, 2), 0);
        check("and", res_of(0), 32'h5);
        run_instr(0, rtype(6'h25, 4, 1, 2), 2);
        check("or", res_of(0), 32'hFFFF_FFFD);
        run_instr(0, rtype(6'h27, 4, 1, 2), 0);
        check("nor", res_of(0), 32'h2);
        run_instr(0, rtype(6'h2A, 5, 2, 1), 0);
        check("slt_t", res_of(0), 32'd1);
        run_instr(0, rtype(6'h2A, 5, 1, 2), 0);
        check("slt_f", res_of(0), 32'd0);
        run_instr(0, rtype(6'h20, 0, 1, 1), 0);
        check("r0_rd", rd_of(0), 5'd0);
        check("r0_res", res_of(0), 32'd10);
        run_instr(0, rtype(6'h20, 6, 0, 0), 0);
        check("r0_read", res_of(0), 32'd0);

        run_instr(0, addi(8, 0, 16'h4000), 0);
        for (int i = 0; i < 17; i++) run_instr(0, rtype(6'h20, 8, 8, 8), 0);
        run_instr(0, addi(8, 8, 16'hFFFF), 0);
        check("max_pos", res_of(0), 32'h7FFF_FFFF);
        run_instr(0, addi(9, 0, 16'd1), 0);
        run_instr(0, rtype(6'h20, 10, 8, 9), 0);
        check("overflow", res_of(0), 32'h8000_0000);

        run_instr(0, 32'hFC00_0000, 0);
        check("illegal_flag", r32_ill, 1);
        run_instr(0, rtype(6'h25, 11, 1, 9), 3);

        // Pending request withdrawn by run; a late response must be ignored.
        run32 = 1'b0;
        #1;
        req_seen = if32.imem_req;
        drive(0, 1'b1, addi(1, 0, 16'h0123));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_seen = req_seen | if32.imem_req;
        end
        check("run_low_req", req_seen, 0);
        drive(0, 1'b0, 32'h0);
        run32 = 1'b1;
        run_instr(0, rtype(6'h20, 12, 1, 0), 0);

        // Reset in the middle of EXEC.
        run_instr(0, addi(1, 0, 16'd77), 0);
        drive(0, 1'b1, addi(2, 0, 16'd99));
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_result", r32_res, 0);
        check("mid_rst_rd", r32_rd, 0);
        check("mid_rst_count", r32_cnt, 0);
        check("mid_rst_pc", r32_pc, 0);
        @(negedge clk);
        check("mid_rst_no_retire", r32_valid, 0);
        reset = 1'b0;
        model_reset();
        run_instr(0, rtype(6'h20, 3, 1, 2), 0);
        run_instr(0, rtype(6'h25, 4, 12, 8), 0);

        for (int i = 0; i < 120; i++)
            run_instr(0, rand_word(), $urandom_range(0, 3));

        check("d16_idle_req", saw16, 0);
        run16 = 1'b1;
        run_instr(1, addi(7, 0, 16'hFFFF), 0);
        check("x16_neg1", res_of(1), 32'h0000_FFFF);
        run_instr(1, addi(9, 0, 16'd42), 1);
        check("x16_alias_rd", rd_of(1), 5'd1);
        run_instr(1, rtype(6'h20, 2, 1, 0), 0);
        check("x16_alias_val", res_of(1), 32'd42);
        for (int i = 0; i < 40; i++)
            run_instr(1, rand_word(), $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
